// File: rtl/audio_pkg.sv
// Shared audio definitions: note half-periods at a 100 MHz clock, duration
// encodings, the end-of-score marker and the sequencer state type.
package audio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_NOTE = 3'd2,
        ST_GAP  = 3'd3,
        ST_END  = 3'd4
    } seq_state_t;

    localparam logic [4:0] EIGHTH   = 5'd1;
    localparam logic [4:0] QUARTER  = 5'd2;
    localparam logic [4:0] HALF     = 5'd4;
    localparam logic [4:0] ONE      = 5'd8;
    localparam logic [4:0] TWO      = 5'd16;
    localparam logic [4:0] END_MARK = 5'd0;

    localparam logic [19:0] REST = 20'd1;

    // Half-period in clock cycles = 100e6 / (2 * f_note), rounded.
    localparam logic [19:0] C2 = 20'd764452, CS2 = 20'd721552, D2 = 20'd681048, DS2 = 20'd642820;
    localparam logic [19:0] E2 = 20'd606740, F2  = 20'd572692, FS2 = 20'd540548, G2 = 20'd510212;
    localparam logic [19:0] GS2 = 20'd481576, A2 = 20'd454545, AS2 = 20'd429032, B2 = 20'd404952;
    localparam logic [19:0] C3 = 20'd382226, CS3 = 20'd360776, D3 = 20'd340524, DS3 = 20'd321410;
    localparam logic [19:0] E3 = 20'd303370, F3  = 20'd286346, FS3 = 20'd270274, G3 = 20'd255106;
    localparam logic [19:0] GS3 = 20'd240788, A3 = 20'd227273, AS3 = 20'd214516, B3 = 20'd202476;
    localparam logic [19:0] C4 = 20'd191113, CS4 = 20'd180388, D4 = 20'd170262, DS4 = 20'd160705;
    localparam logic [19:0] E4 = 20'd151685, F4  = 20'd143173, FS4 = 20'd135137, G4 = 20'd127553;
    localparam logic [19:0] GS4 = 20'd120394, A4 = 20'd113636, AS4 = 20'd107258, B4 = 20'd101238;

endpackage

// File: rtl/tone_sequencer_if.sv
// Score memory bus: the sequencer presents an address, the score ROM answers
// combinationally with the half-period and duration of that entry.
interface tone_sequencer_if #(
    parameter int PERIOD_W = 20,
    parameter int DUR_W    = 5,
    parameter int ADDR_W   = 10
);
    logic [ADDR_W-1:0]   score_addr;
    logic [PERIOD_W-1:0] score_period;
    logic [DUR_W-1:0]    score_dur;

    modport master (output score_addr, input score_period, input score_dur);
    modport slave  (input score_addr, output score_period, output score_dur);
endinterface

// File: rtl/tone_sequencer_tone_div.sv
// Loadable half-period divider: counts 0..period-1 while enabled and flips
// its phase on each wrap. Load restarts the phase low.
module tone_div #(
    parameter int PERIOD_W = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clr,
    input  logic                load,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period_in,
    output logic                phase,
    output logic                wrap,
    output logic                silent
);
    logic [PERIOD_W-1:0] period_r;
    logic [PERIOD_W-1:0] cnt_r;
    logic                phase_r;

    assign wrap   = en && (cnt_r == (period_r - PERIOD_W'(1)));
    assign silent = (period_r <= PERIOD_W'(1));
    assign phase  = phase_r;

    // Divider count, latched period and output phase.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            period_r <= '0;
            cnt_r    <= '0;
            phase_r  <= 1'b0;
        end else if (load) begin
            period_r <= period_in;
            cnt_r    <= '0;
            phase_r  <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt_r   <= '0;
                phase_r <= ~phase_r;
            end else begin
                cnt_r <= cnt_r + PERIOD_W'(1);
            end
        end
    end
endmodule

// File: rtl/tone_sequencer.sv
// Single-voice square-wave score player: walks (half-period, duration) entries
// from an external ROM, with end marker, loop, pause and an articulation gap.
module tone_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_CYCLES = CLK_HZ / 8,
    parameter int GAP_CYCLES  = CLK_HZ / 100,
    parameter int PERIOD_W    = 20,
    parameter int DUR_W       = 5,
    parameter int ADDR_W      = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             play,
    input  logic             pause,
    input  logic             loop_en,
    tone_sequencer_if.master score,
    output logic             audio_out,
    output logic             aud_sd,
    output logic             busy,
    output logic             done
);
    localparam int              CNT_W  = DUR_W + $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] TICK_K = CNT_W'(TICK_CYCLES);
    localparam logic [CNT_W-1:0] GAP_K  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] ONE_K  = CNT_W'(1);

    seq_state_t        state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [CNT_W-1:0]  time_r, time_s;
    logic              finished_r, finished_s;
    logic              div_clr_s, div_load_s, div_en_s;
    logic              tone_phase_s, tone_wrap_s, tone_silent_s;
    logic              audio_r, busy_r, done_r;
    logic [CNT_W-1:0]  note_len_s;

    // One timer covers the sounded part of the note, then the gap.
    assign note_len_s = (CNT_W'(score.score_dur) * TICK_K) - GAP_K;

    tone_div #(.PERIOD_W(PERIOD_W)) u_tone_div (
        .clock     (clock),
        .reset     (reset),
        .clr       (div_clr_s),
        .load      (div_load_s),
        .en        (div_en_s),
        .period_in (score.score_period),
        .phase     (tone_phase_s),
        .wrap      (tone_wrap_s),
        .silent    (tone_silent_s)
    );

    // Next-state logic; play=0 rewinds from anywhere, pause freezes everything.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        time_s     = time_r;
        finished_s = finished_r;
        div_clr_s  = 1'b0;
        div_load_s = 1'b0;
        div_en_s   = 1'b0;
        if (!play) begin
            state_s    = ST_IDLE;
            addr_s     = '0;
            time_s     = '0;
            finished_s = 1'b0;
            div_clr_s  = 1'b1;
        end else if (pause) begin
            state_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!finished_r) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    div_load_s = 1'b1;
                    if (score.score_dur != DUR_W'(END_MARK)) begin
                        state_s = ST_NOTE;
                        time_s  = note_len_s;
                    end else if (loop_en) begin
                        addr_s = '0;
                    end else begin
                        state_s = ST_END;
                    end
                end
                ST_NOTE: begin
                    div_en_s = 1'b1;
                    time_s   = time_r - ONE_K;
                    if (time_r > ONE_K) begin
                        state_s = ST_NOTE;
                    end else if (GAP_K == '0) begin
                        state_s = ST_LOAD;
                        addr_s  = addr_r + ADDR_W'(1);
                    end else begin
                        state_s = ST_GAP;
                        time_s  = GAP_K;
                    end
                end
                ST_GAP: begin
                    time_s = time_r - ONE_K;
                    if (time_r > ONE_K) begin
                        state_s = ST_GAP;
                    end else begin
                        state_s = ST_LOAD;
                        addr_s  = addr_r + ADDR_W'(1);
                        time_s  = '0;
                    end
                end
                ST_END: begin
                    state_s    = ST_IDLE;
                    finished_s = 1'b1;
                end
                default: begin
                    state_s = ST_IDLE;
                    addr_s  = '0;
                    time_s  = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            addr_r     <= '0;
            time_r     <= '0;
            finished_r <= 1'b0;
            audio_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            addr_r     <= addr_s;
            time_r     <= time_s;
            finished_r <= finished_s;
            busy_r     <= (state_s == ST_LOAD) || (state_s == ST_NOTE) || (state_s == ST_GAP);
            done_r     <= (state_s == ST_END) && (state_r != ST_END);
            audio_r    <= div_en_s && (state_s == ST_NOTE) && !tone_silent_s
                          && (tone_phase_s ^ tone_wrap_s);
        end
    end

    assign score.score_addr = addr_r;
    assign audio_out        = audio_r;
    assign busy             = busy_r;
    assign aud_sd           = busy_r;
    assign done             = done_r;
endmodule
